fp_arith_unit: RTL
==================

Name: fp_arith_unit

Overview:
Shared prime-field arithmetic engine that serves the xDBLADD / ladder controllers. It executes one operation per request on the A/B/op bus: Montgomery multiply, modular add or modular subtract. The controller starts a request by dropping rst_mul and collects the result on done_mul. Multiplication is word-serial CIOS Montgomery (one word_size digit of A per iteration), so area stays bounded at N=512.

Parameters:
N, 512, field element width (bits); must be a multiple of word_size.
word_size, 32, digit width of the word-serial multiplier.
p, CSIDH-512 prime (same constant as the controllers), modulus.
p_inv, (-p)^-1 mod 2^N (same constant as the controllers); only bits [word_size-1:0] are used.

Ports:
clk  in  1  clock.
rst  in  1  global reset; asynchronous, active-low.
A  in  N  operand A, must be < p; sampled only at start.
B  in  N  operand B, must be < p; sampled only at start.
op  in  2  00 = Montgomery mul (A·B·2^-N mod p), 01 = add (A+B mod p), 10 = sub (A−B mod p), 11 = reserved.
rst_mul  in  1  synchronous request/abort: 1 holds the unit idle, 1→0 starts an operation.
mul  out  N  result, always < p; stable while done_mul=1.
done_mul  out  1  result valid; held until rst_mul=1.

Behaviour:
- Global reset (rst=0, async): state=IDLE, mul=0, done_mul=0, all internal registers 0.
- S = N/word_size digits; t accumulator is N+word_size+2 bits wide; pw = p_inv[word_size-1:0].
- IDLE: at an edge with rst_mul=0, latch A, B and op, clear t, set i=0, then go to ACC (op=00), ADDSUB (op=01/10) or RSV (op=11). This edge is E0.
- ACC: t ← t + a_i·B, where a_i = A[i*w +: w]; go to RED.
- RED: m = (t[w-1:0]·pw) mod 2^w; t ← (t + m·p) >> w. If i==S−1 go to FINAL, else i++ and go to ACC.
- FINAL: mul ← (t ≥ p) ? t−p : t; done_mul ← 1; go to DONE. done_mul rises after edge E(2S+1), i.e. E33 at default parameters.
- ADDSUB: compute raw = A+B (op 01) or A−B+p (op 10) in N+1 bits; go to FIX.
- FIX: mul ← (raw ≥ p) ? raw−p : raw; done_mul ← 1; go to DONE. done_mul rises after E2.
- RSV (op 11): mul ← 0; done_mul ← 1 after E1.
- DONE: hold mul and done_mul. At the first edge with rst_mul=1, done_mul ← 0, go to IDLE; mul keeps its value.
- rst_mul=1 in any state other than IDLE aborts the operation: go to IDLE, done_mul ← 0, mul unchanged, no result produced.
- Back-to-back requests: the controller raises rst_mul for exactly one cycle after capturing a result. done_mul must therefore be 0 by the edge where rst_mul returns to 0, and a new start must be accepted at that same edge. No dead cycle is allowed.
- Operands must be < p; out-of-range inputs are not checked, and the result is then undefined but still produced in the nominal latency.
- Latency is data-independent (constant time): the final conditional subtract is a mux, with no early exit.

Decomposition:
- Shared package fp_pkg:
  - op encodings OP_MUL=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_RSV=2'b11;
  - state enum (IDLE, ACC, RED, FINAL, ADDSUB, FIX, RSV, DONE);
  - localparam S=N/word_size;
  - default p, p_inv and fp1 (2^N mod p) constants, shared with the xDBLADD controllers.
- One combinational sub-module, fp_mont_row: given t, a digit d, multiplicand X and a select, it returns t + d·X, with optional >>w. It is used for both the ACC step (d=a_i, X=B) and the RED step (d=m, X=p).

Test Plan:
- Montgomery identity: op=00, A=B=fp1 → done_mul after exactly 33 cycles, mul=fp1. Repeat with A=X (random < p), B=fp1 → mul=X.
- Add wrap: op=01, A=p−1, B=1 → mul=0 after 2 cycles. Also A=5, B=7 → mul=12.
- Sub borrow: op=10, A=0, B=1 → mul=p−1. Also A=9, B=4 → mul=5. Both complete in 2 cycles.
- Handshake: drive the controller pattern (capture, rst_mul=1 for one cycle, then 0) across 20 random mul/add/sub ops. Every result must match a reference model; done_mul must never be seen high during a cycle with rst_mul=1, and no start may be lost.
- Abort: start op=00, assert rst_mul at cycle 10 → done_mul stays 0 and the unit returns to IDLE. The next op=01 with A=5, B=7 → mul=12 after 2 cycles.
- Async reset: pull rst low mid-multiply, between clock edges → mul=0 and done_mul=0 immediately. After rst is released, op=00 with A=B=fp1 → mul=fp1 after 33 cycles.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the prime-field arithmetic engine and the xDBLADD controllers.
package fp_pkg;

  localparam int unsigned FP_N = 512;
  localparam int unsigned FP_W = 32;
  localparam int unsigned S    = FP_N / FP_W;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_RSV = 2'b11
  } fp_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_RED,
    ST_FINAL,
    ST_ADDSUB,
    ST_FIX,
    ST_RSV,
    ST_DONE
  } fp_state_e;

  localparam logic [FP_N-1:0] FP_P =
    512'h65b48e8f740f89bffc8ab0d15e3e4c4ab42d083aedc88c425afbfcc69322c9cda7aac6c567f35507516730cc1f0b4f25c2721bf457aca8351b81b90533c6c87b;

  // Newton iteration doubles the number of correct low bits each step; x=m is already
  // correct to 3 bits for odd m, so 9 steps cover 512 bits.
  function automatic logic [FP_N-1:0] calc_neg_inv(input logic [FP_N-1:0] m);
    logic [FP_N-1:0] x;
    x = m;
    for (int unsigned k = 0; k < 9; k++) begin
      x = x * (FP_N'(2) - m * x);
    end
    return '0 - x;
  endfunction

  function automatic logic [FP_N-1:0] calc_r_mod_p(input logic [FP_N-1:0] m);
    logic [FP_N:0] r;
    r = (FP_N+1)'(1);
    for (int unsigned k = 0; k < FP_N; k++) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[FP_N-1:0];
  endfunction

  localparam logic [FP_N-1:0] FP_P_INV = calc_neg_inv(FP_P);
  localparam logic [FP_N-1:0] FP1      = calc_r_mod_p(FP_P);

endpackage

// File: rtl/fp_mont_row.sv
// One multiply-accumulate row of the word-serial Montgomery multiplier: t + d*X, optionally >> W.
module fp_mont_row #(
  parameter int unsigned N  = 512,
  parameter int unsigned W  = 32,
  parameter int unsigned TW = N + W + 2
) (
  input  logic [TW-1:0] t_i,
  input  logic [W-1:0]  d_i,
  input  logic [N-1:0]  x_i,
  input  logic          shift_i,
  output logic [TW-1:0] t_o
);

  logic [TW-1:0] sum;

  always_comb begin
    sum = t_i + TW'(d_i) * TW'(x_i);
    t_o = shift_i ? (sum >> W) : sum;
  end

endmodule

// File: rtl/fp_arith_unit.sv
// Shared prime-field engine: CIOS Montgomery multiply, modular add and modular subtract.
module fp_arith_unit
  import fp_pkg::*;
#(
  parameter int unsigned   N         = FP_N,
  parameter int unsigned   word_size = FP_W,
  parameter logic [N-1:0]  p         = FP_P,
  parameter logic [N-1:0]  p_inv     = FP_P_INV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [1:0]   op,
  input  logic         rst_mul,
  output logic [N-1:0] mul,
  output logic         done_mul
);

  localparam int unsigned SD = N / word_size;
  localparam int unsigned TW = N + word_size + 2;
  localparam int unsigned IW = (SD > 1) ? $clog2(SD) : 1;

  fp_state_e            state_q, state_d;
  fp_op_e               op_q, op_d;
  logic [N-1:0]         a_q, a_d;
  logic [N-1:0]         b_q, b_d;
  logic [TW-1:0]        t_q, t_d;
  logic [IW-1:0]        i_q, i_d;
  logic [N-1:0]         mul_q, mul_d;
  logic                 done_q, done_d;

  logic [word_size-1:0] pw;
  logic [word_size-1:0] m;
  logic                 red;
  logic [word_size-1:0] row_d;
  logic [N-1:0]         row_x;
  logic [TW-1:0]        row_t;
  logic [N:0]           raw;
  logic [TW-1:0]        t_sub;
  logic [N-1:0]         fin;

  assign pw = p_inv[word_size-1:0];

  always_comb begin
    m     = t_q[word_size-1:0] * pw;
    red   = (state_q == ST_RED);
    row_d = red ? m : a_q[word_size-1:0];
    row_x = red ? p : b_q;
  end

  fp_mont_row #(
    .N  (N),
    .W  (word_size),
    .TW (TW)
  ) u_row (
    .t_i     (t_q),
    .d_i     (row_d),
    .x_i     (row_x),
    .shift_i (red),
    .t_o     (row_t)
  );

  // Constant-time final correction shared by FINAL and FIX.
  always_comb begin
    if (op_q == OP_SUB) raw = {1'b0, a_q} - {1'b0, b_q} + {1'b0, p};
    else                raw = {1'b0, a_q} + {1'b0, b_q};
    t_sub = t_q - TW'(p);
    fin   = (t_q >= TW'(p)) ? t_sub[N-1:0] : t_q[N-1:0];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    t_d     = t_q;
    i_d     = i_q;
    mul_d   = mul_q;
    done_d  = done_q;
    if (rst_mul) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          a_d  = A;
          b_d  = B;
          op_d = fp_op_e'(op);
          t_d  = '0;
          i_d  = '0;
          case (op)
            OP_MUL:         state_d = ST_ACC;
            OP_ADD, OP_SUB: state_d = ST_ADDSUB;
            default:        state_d = ST_RSV;
          endcase
        end
        ST_ACC: begin
          t_d     = row_t;
          state_d = ST_RED;
        end
        ST_RED: begin
          t_d = row_t;
          // A is consumed by shifting so the current digit always sits in the low word.
          a_d = a_q >> word_size;
          if (i_q == IW'(SD - 1)) begin
            state_d = ST_FINAL;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = ST_ACC;
          end
        end
        ST_FINAL, ST_FIX: begin
          mul_d   = fin;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        ST_ADDSUB: begin
          t_d     = TW'(raw);
          state_d = ST_FIX;
        end
        ST_RSV: begin
          mul_d   = '0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      i_q     <= '0;
      mul_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      t_q     <= t_d;
      i_q     <= i_d;
      mul_q   <= mul_d;
      done_q  <= done_d;
    end
  end

  assign mul      = mul_q;
  assign done_mul = done_q;

endmodule
